// File: rtl/word_unpacker_if.sv
`timescale 1ns/1ps
// word_unpacker_if
//   Bundles the word-side and slice-side handshakes of word_unpacker.
//   Parameters mirror the unpacker: LANE_W bits per slice, LANES slices per word.
//   Signals:
//     in_valid  / in_ready  / in_data  : packed word input (WORD_W bits)
//     out_valid / out_ready / out_data : one LANE_W-bit slice per cycle
//     out_idx                          : emission position 0..LANES-1
//     out_last                         : final slice of the held word
//     busy                             : word held, slices pending (== out_valid)
//   Modports:
//     slave  : the unpacker's view (consumes words, produces slices)
//     master : the surrounding logic's view (produces words, consumes slices)
interface word_unpacker_if #(
   parameter int LANE_W = 1,
   parameter int LANES  = 5
);
   localparam int WORD_W = LANE_W * LANES;
   localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [LANE_W-1:0] out_data;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic              busy;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last, busy
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last, busy
   );
endinterface

// File: rtl/word_unpacker.sv
`timescale 1ns/1ps
// word_unpacker
//   Takes one packed WORD_W-bit word over valid/ready and emits it as LANES
//   slices of LANE_W bits, one slice per cycle, tagged with out_idx/out_last.
//   Latency from word accept to first slice is one cycle; the slice data,
//   index and last flag all come straight from flops.
//   A new word may be accepted on the same edge that the last slice of the
//   current word is consumed, so back-to-back words stream with no bubble.
// Ports
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset; in_ready is forced low while high
//   bus  : word_unpacker_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data/out_idx/out_last, busy)
// Configuration
//   WORD_UNPACK_MSB_FIRST_EN undefined : slice at emission position p is
//                                        in_data[p*LANE_W +: LANE_W]
//   WORD_UNPACK_MSB_FIRST_EN defined   : slice at emission position p is
//                                        in_data[(LANES-1-p)*LANE_W +: LANE_W]
//   out_idx always counts 0..LANES-1 in emission order.
module word_unpacker #(
   parameter int LANE_W = 1,
   parameter int LANES  = 5
) (
   input logic            clk,
   input logic            rst,
   word_unpacker_if.slave bus
);
   localparam int WORD_W = LANE_W * LANES;
   localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

`ifdef WORD_UNPACK_MSB_FIRST_EN
   localparam bit MSB_FIRST = 1'b1;
`else
   localparam bit MSB_FIRST = 1'b0;
`endif

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   state_t            state_q,    state_d;
   logic [IDX_W-1:0]  cnt_q,      cnt_d;
   logic [WORD_W-1:0] hold_q,     hold_d;
   logic [LANE_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;

   logic              in_ready;
   logic              load;
   logic              out_hs;
   logic [31:0]       cnt_nxt;

   // Slice presented at emission position pos, honouring the emission order.
   function automatic logic [LANE_W-1:0] slice_at(input logic [WORD_W-1:0] w,
                                                  input logic [31:0]       pos);
      logic [31:0] sel;
      slice_at = '0;
      sel      = MSB_FIRST ? (32'(LANES) - 32'd1 - pos) : pos;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (k == sel) begin
            slice_at = w[k*LANE_W +: LANE_W];
         end
      end
   endfunction

   assign cnt_nxt  = 32'(cnt_q) + 32'd1;

   // Ready when empty, or when the last slice leaves this very cycle.
   assign in_ready = !rst && ((state_q == IDLE) ||
                              ((state_q == EMIT) && out_last_q && bus.out_ready));
   assign load     = bus.in_valid && in_ready;
   assign out_hs   = (state_q == EMIT) && bus.out_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      hold_d     = hold_q;
      out_data_d = out_data_q;
      out_last_d = out_last_q;

      // load can only fire when idle or on the last-slice handshake, so giving
      // it priority also covers the reload-on-last case.
      if (load) begin
         state_d    = EMIT;
         cnt_d      = '0;
         hold_d     = bus.in_data;
         out_data_d = slice_at(bus.in_data, 32'd0);
         out_last_d = (LANES == 1);
      end else if (out_hs) begin
         if (!out_last_q) begin
            cnt_d      = cnt_nxt[IDX_W-1:0];
            out_data_d = slice_at(hold_q, cnt_nxt);
            out_last_d = (cnt_nxt == 32'(LANES - 1));
         end else begin
            state_d    = IDLE;
            cnt_d      = '0;
            out_data_d = '0;
            out_last_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         hold_q     <= '0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == EMIT);
   assign bus.busy      = (state_q == EMIT);
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = cnt_q;
   assign bus.out_last  = out_last_q;

`ifndef SYNTHESIS
   a_stall_hold : assert property (@(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=>
         (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_idx) &&
          $stable(bus.out_last)));

   a_cnt_range : assert property (@(posedge clk) int'(cnt_q) <= LANES - 1);
`endif

endmodule

// File: tb/tb_word_unpacker.sv
`timescale 1ns/1ps
// tb_word_unpacker
//   Three unpacker instances: A (1x5), B (2x2), C (8x1).
//   Expected slices come from a shift-and-mask model of the word layout.
module tb_word_unpacker;

`ifdef WORD_UNPACK_MSB_FIRST_EN
   localparam bit MSB = 1'b1;
`else
   localparam bit MSB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   word_unpacker_if #(.LANE_W(1), .LANES(5)) ia ();
   word_unpacker_if #(.LANE_W(2), .LANES(2)) ib ();
   word_unpacker_if #(.LANE_W(8), .LANES(1)) ic ();

   word_unpacker #(.LANE_W(1), .LANES(5)) u_a (.clk(clk), .rst(rst), .bus(ia));
   word_unpacker #(.LANE_W(2), .LANES(2)) u_b (.clk(clk), .rst(rst), .bus(ib));
   word_unpacker #(.LANE_W(8), .LANES(1)) u_c (.clk(clk), .rst(rst), .bus(ic));

   // Slice expected at emission position p of word w.
   function automatic logic [7:0] exp_slice(input logic [39:0] w, input int lw,
                                            input int lanes, input int p);
      int          pos;
      logic [39:0] mask;
      logic [39:0] t;
      pos  = MSB ? (lanes - 1 - p) : p;
      mask = (40'd1 << lw) - 40'd1;
      t    = (w >> (pos * lw)) & mask;
      return t[7:0];
   endfunction

   task automatic test_reset();
      ia.in_valid = 0; ia.in_data = '0; ia.out_ready = 0;
      ib.in_valid = 0; ib.in_data = '0; ib.out_ready = 0;
      ic.in_valid = 0; ic.in_data = '0; ic.out_ready = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      if (ia.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready_forced got=%0b exp=0", ia.in_ready); end
      n_cmp++;
      if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", ia.out_valid); end
      n_cmp++;
      rst = 0;
      #1;
      if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%0b exp=1", ia.in_ready); end
      n_cmp++;
      if (ia.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy got=%0b exp=0", ia.busy); end
      n_cmp++;
      if (ia.out_data !== 1'b0) begin n_err++; $display("FAIL post_reset_out_data got=%0h exp=0", ia.out_data); end
      n_cmp++;
      if (ia.out_idx !== 3'd0) begin n_err++; $display("FAIL post_reset_out_idx got=%0d exp=0", ia.out_idx); end
      n_cmp++;
      if (ia.out_last !== 1'b0) begin n_err++; $display("FAIL post_reset_out_last got=%0b exp=0", ia.out_last); end
      n_cmp++;
      if (ib.in_ready !== 1'b1 || ic.in_ready !== 1'b1) begin
         n_err++; $display("FAIL post_reset_in_ready_bc got=%0b%0b exp=11", ib.in_ready, ic.in_ready);
      end
      n_cmp++;
      @(posedge clk); #1;
   endtask

   // T1: 5'b11001, out_ready held high.
   task automatic test_single_word();
      logic ev [5];
      if (MSB) ev = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      else     ev = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      ia.in_valid = 1; ia.in_data = 5'b11001; ia.out_ready = 1;
      #1;
      if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL t1_accept_ready got=%0b exp=1", ia.in_ready); end
      n_cmp++;
      @(posedge clk); #1;
      ia.in_valid = 0; ia.in_data = 5'($urandom);
      #1;
      for (int p = 0; p < 5; p++) begin
         if (ia.out_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid p=%0d got=%0b exp=1", p, ia.out_valid); end
         n_cmp++;
         if (ia.out_data !== ev[p]) begin n_err++; $display("FAIL t1_data p=%0d got=%0b exp=%0b", p, ia.out_data, ev[p]); end
         n_cmp++;
         if (ia.out_idx !== 3'(p)) begin n_err++; $display("FAIL t1_idx got=%0d exp=%0d", ia.out_idx, p); end
         n_cmp++;
         if (ia.out_last !== (p == 4)) begin n_err++; $display("FAIL t1_last p=%0d got=%0b exp=%0b", p, ia.out_last, p == 4); end
         n_cmp++;
         if (ia.in_ready !== (p == 4)) begin n_err++; $display("FAIL t1_in_ready p=%0d got=%0b exp=%0b", p, ia.in_ready, p == 4); end
         n_cmp++;
         @(posedge clk); #1;
         ia.in_data = 5'($urandom);
         #1;
      end
      if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
         n_err++; $display("FAIL t1_done valid/ready got=%0b/%0b exp=0/1", ia.out_valid, ia.in_ready);
      end
      n_cmp++;
   endtask

   // T2: 4'hC then 4'h3 back-to-back on the 2x2 instance.
   task automatic test_back_to_back();
      logic [3:0] words [2];
      words = '{4'hC, 4'h3};
      ib.in_valid = 1; ib.in_data = words[0]; ib.out_ready = 1;
      @(posedge clk); #1;
      ib.in_data = words[1];
      #1;
      for (int c = 0; c < 4; c++) begin
         logic [1:0] e;
         e = exp_slice(40'(words[c/2]), 2, 2, c % 2)[1:0];
         if (ib.out_valid !== 1'b1) begin n_err++; $display("FAIL t2_valid c=%0d got=%0b exp=1", c, ib.out_valid); end
         n_cmp++;
         if (ib.out_data !== e) begin n_err++; $display("FAIL t2_data c=%0d got=%0h exp=%0h", c, ib.out_data, e); end
         n_cmp++;
         if (ib.out_idx !== 1'(c % 2)) begin n_err++; $display("FAIL t2_idx c=%0d got=%0d exp=%0d", c, ib.out_idx, c % 2); end
         n_cmp++;
         if (ib.in_ready !== (c % 2 == 1)) begin n_err++; $display("FAIL t2_in_ready c=%0d got=%0b exp=%0b", c, ib.in_ready, c % 2 == 1); end
         n_cmp++;
         @(posedge clk); #1;
         if (c == 1) ib.in_valid = 0;
         #1;
      end
      if (ib.out_valid !== 1'b0) begin n_err++; $display("FAIL t2_drained got=%0b exp=0", ib.out_valid); end
      n_cmp++;
   endtask

   // T3: stall three cycles while idx 2 is presented.
   task automatic test_backpressure();
      logic pat [8];
      int   p;
      pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      p = 0;
      @(posedge clk); #1;
      ia.in_valid = 1; ia.in_data = 5'b11001; ia.out_ready = 1;
      @(posedge clk); #1;
      ia.in_valid = 0;
      for (int c = 0; c < 8; c++) begin
         ia.out_ready = pat[c];
         ia.in_data = 5'($urandom);
         #1;
         if (ia.out_valid !== 1'b1) begin n_err++; $display("FAIL t3_valid c=%0d got=%0b exp=1", c, ia.out_valid); end
         n_cmp++;
         if (ia.out_idx !== 3'(p)) begin n_err++; $display("FAIL t3_idx c=%0d got=%0d exp=%0d", c, ia.out_idx, p); end
         n_cmp++;
         if (ia.out_data !== exp_slice(40'b11001, 1, 5, p)[0]) begin
            n_err++; $display("FAIL t3_data c=%0d got=%0b exp=%0b", c, ia.out_data, exp_slice(40'b11001, 1, 5, p)[0]);
         end
         n_cmp++;
         if (ia.in_ready !== (p == 4 && pat[c])) begin n_err++; $display("FAIL t3_in_ready c=%0d got=%0b", c, ia.in_ready); end
         n_cmp++;
         @(posedge clk); #1;
         if (pat[c]) p++;
      end
      #1;
      if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL t3_total_cycles valid got=%0b exp=0", ia.out_valid); end
      n_cmp++;
   endtask

   // T4: reset mid-word, then a fresh word starts cleanly at idx 0.
   task automatic test_reset_mid_word();
      @(posedge clk); #1;
      ia.in_valid = 1; ia.in_data = 5'b11001; ia.out_ready = 1;
      @(posedge clk); #1;
      ia.in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1;
      #1;
      if (ia.in_ready !== 1'b0) begin n_err++; $display("FAIL t4_ready_in_rst got=%0b exp=0", ia.in_ready); end
      n_cmp++;
      @(posedge clk); #1;
      rst = 0;
      #1;
      if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin
         n_err++; $display("FAIL t4_after_rst valid/ready got=%0b/%0b exp=0/1", ia.out_valid, ia.in_ready);
      end
      n_cmp++;
      ia.in_valid = 1; ia.in_data = 5'b00110;
      @(posedge clk); #1;
      ia.in_valid = 0;
      #1;
      for (int p = 0; p < 5; p++) begin
         if (ia.out_valid !== 1'b1 || ia.out_idx !== 3'(p) ||
             ia.out_data !== exp_slice(40'b00110, 1, 5, p)[0] || ia.out_last !== (p == 4)) begin
            n_err++;
            $display("FAIL t4_slice p=%0d got v=%0b idx=%0d d=%0b l=%0b exp v=1 idx=%0d d=%0b l=%0b", p,
                     ia.out_valid, ia.out_idx, ia.out_data, ia.out_last, p, exp_slice(40'b00110, 1, 5, p)[0], p == 4);
         end
         n_cmp++;
         @(posedge clk); #2;
      end
      if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL t4_no_stale got=%0b exp=0", ia.out_valid); end
      n_cmp++;
   endtask

   // Random words and random backpressure on the 1x5 instance against a slice queue.
   task automatic test_random_stream();
      int   qd [$];
      int   qi [$];
      int   sent;
      int   cyc;
      logic [4:0] w;
      logic exp_rdy;
      sent = 0; cyc = 0;
      while ((sent < 30 || qd.size() != 0) && cyc < 2000) begin
         @(posedge clk); #1;
         ia.out_ready = ($urandom % 4) != 0;
         ia.in_valid  = (sent < 30) && (($urandom % 3) != 0);
         w = 5'($urandom);
         ia.in_data = w;
         #1;
         exp_rdy = (qd.size() == 0) || (qd.size() == 1 && ia.out_ready);
         if (ia.in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%0b exp=%0b", cyc, ia.in_ready, exp_rdy); end
         n_cmp++;
         if (ia.out_valid !== (qd.size() != 0) || ia.busy !== (qd.size() != 0)) begin
            n_err++; $display("FAIL rnd_valid cyc=%0d got=%0b busy=%0b exp=%0b", cyc, ia.out_valid, ia.busy, qd.size() != 0);
         end
         n_cmp++;
         if (ia.out_valid && ia.out_ready && qd.size() != 0) begin
            if (ia.out_data !== qd[0][0] || ia.out_idx !== 3'(qi[0]) || ia.out_last !== (qi[0] == 4)) begin
               n_err++;
               $display("FAIL rnd_slice cyc=%0d got d=%0b idx=%0d l=%0b exp d=%0b idx=%0d l=%0b", cyc,
                        ia.out_data, ia.out_idx, ia.out_last, qd[0][0], qi[0], qi[0] == 4);
            end
            n_cmp++;
            void'(qd.pop_front());
            void'(qi.pop_front());
         end
         if (ia.in_valid && ia.in_ready) begin
            for (int p = 0; p < 5; p++) begin
               qd.push_back(int'(exp_slice(40'(w), 1, 5, p)));
               qi.push_back(p);
            end
            sent++;
         end
         cyc++;
      end
      ia.in_valid = 0;
      if (qd.size() != 0 || sent < 30) begin n_err++; $display("FAIL rnd_timeout sent=%0d pending=%0d exp 30/0", sent, qd.size()); end
      n_cmp++;
   endtask

   // T5: single-lane instance as a registered buffer; in_valid held until taken.
   task automatic test_single_lane();
      logic [7:0] q [$];
      logic [7:0] w;
      logic pend;
      logic exp_rdy;
      int   sent;
      int   got;
      int   cyc;
      pend = 0; sent = 0; got = 0; cyc = 0; w = '0;
      while ((sent < 20 || q.size() != 0) && cyc < 2000) begin
         @(posedge clk); #1;
         if (!pend && sent < 20 && ($urandom % 2) != 0) begin
            pend = 1;
            w = (sent == 0) ? 8'hA5 : (sent == 1) ? 8'h5A : 8'($urandom);
         end
         ic.in_valid  = pend;
         ic.in_data   = pend ? w : 8'($urandom);
         ic.out_ready = ($urandom % 2) != 0;
         #1;
         exp_rdy = (q.size() == 0) || (q.size() == 1 && ic.out_ready);
         if (ic.in_ready !== exp_rdy) begin n_err++; $display("FAIL t5_in_ready cyc=%0d got=%0b exp=%0b", cyc, ic.in_ready, exp_rdy); end
         n_cmp++;
         if (ic.out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL t5_valid cyc=%0d got=%0b exp=%0b", cyc, ic.out_valid, q.size() != 0); end
         n_cmp++;
         if (ic.out_valid && ic.out_ready && q.size() != 0) begin
            if (ic.out_data !== q[0] || ic.out_idx !== 1'b0 || ic.out_last !== 1'b1) begin
               n_err++;
               $display("FAIL t5_word n=%0d got d=%0h idx=%0d l=%0b exp d=%0h idx=0 l=1", got, ic.out_data, ic.out_idx, ic.out_last, q[0]);
            end
            n_cmp++;
            void'(q.pop_front());
            got++;
         end
         if (ic.in_valid && ic.in_ready) begin
            q.push_back(w);
            sent++;
            pend = 0;
         end
         cyc++;
      end
      ic.in_valid = 0;
      if (got != 20) begin n_err++; $display("FAIL t5_word_count got=%0d exp=20", got); end
      n_cmp++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_random_stream();
      test_single_lane();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not complete got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
